cam_result_collector: RTL

//  Downstream stage of the CAM search port. It tracks one outstanding search,

---
 rtl/cam_result_collector.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cam_result_collector.sv
// ============================================================================
// Module      : cam_result_collector
// Description : Tracks one outstanding CAM search, acknowledges captured hits
//               and queues hit/miss records in a FWFT valid/ready FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_result_collector #(
    parameter int CAM_DW  = 32,
    parameter int CAM_AW  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              srch_req,
    input  logic              cam_hit,
    input  logic [CAM_AW-1:0] cam_addr,
    input  logic [CAM_DW-1:0] cam_data,
    output logic              cam_ack,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_hit,
    output logic [CAM_AW-1:0] res_addr,
    output logic [CAM_DW-1:0] res_data,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
    output logic              overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [TW-1:0]     r_timer;
    logic [TW-1:0]     w_timer_next;
    logic              r_cam_ack;
    logic              w_ack_next;

    logic              w_push;
    logic              w_push_hit;
    logic [CAM_AW-1:0] w_push_addr;
    logic [CAM_DW-1:0] w_push_data;
    logic              w_drop;
    logic              w_pop;
    logic              w_full;

    logic              r_mem_hit  [DEPTH];
    logic [CAM_AW-1:0] r_mem_addr [DEPTH];
    logic [CAM_DW-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [15:0]       r_hit_cnt;
    logic [15:0]       r_miss_cnt;
    logic              r_overflow;

    // Full comes from the registered count, so a same-cycle pop never frees a slot.
    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = res_valid & res_ready;

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_push       = 1'b0;
        w_push_hit   = 1'b0;
        w_push_addr  = '0;
        w_push_data  = '0;
        w_drop       = 1'b0;
        w_ack_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (srch_req) begin
                    w_state_next = ST_WAIT;
                    w_timer_next = '0;
                end
            end
            ST_WAIT: begin
                if (cam_hit) begin
                    // A hit against a full FIFO is held off, timer frozen, CAM not acked.
                    if (!w_full) begin
                        w_push       = 1'b1;
                        w_push_hit   = 1'b1;
                        w_push_addr  = cam_addr;
                        w_push_data  = cam_data;
                        w_ack_next   = 1'b1;
                        w_state_next = ST_ACK;
                    end
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_push       = !w_full;
                    w_drop       = w_full;
                    w_state_next = ST_IDLE;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            ST_ACK: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_cam_ack <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_cam_ack <= w_ack_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_hit[i]  <= 1'b0;
                r_mem_addr[i] <= '0;
                r_mem_data[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_hit[r_wr_ptr]  <= w_push_hit;
                r_mem_addr[r_wr_ptr] <= w_push_addr;
                r_mem_data[r_wr_ptr] <= w_push_data;
                r_wr_ptr             <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push && w_push_hit && (r_hit_cnt != 16'hFFFF)) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if (w_push && !w_push_hit && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign cam_ack   = r_cam_ack;
    assign busy      = (r_state != ST_IDLE);
    assign res_valid = (r_count != '0);
    assign res_hit   = r_mem_hit[r_rd_ptr];
    assign res_addr  = r_mem_addr[r_rd_ptr];
    assign res_data  = r_mem_data[r_rd_ptr];
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire
